// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_pkg
//  Description : Shared types and helpers for the fetch program-counter unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

  // Next-PC source selector
  typedef enum logic [1:0] {
    NPC_SEQ      = 2'd0,
    NPC_REDIRECT = 2'd1,
    NPC_RAS      = 2'd2,
    NPC_HOLD     = 2'd3
  } npc_sel_e;

  // Widest PC the alignment helper supports
  localparam int c_MAX_XLEN = 64;

  // Mask that clears the instruction-offset bits of an address; callers
  // truncate the result to their own PC width.
  function automatic logic [c_MAX_XLEN-1:0] alignMask(input int instrBytes);
    return ~(c_MAX_XLEN'(instrBytes) - c_MAX_XLEN'(1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ras_stack.sv
`default_nettype none
// ============================================================================
//  Module      : ras_stack
//  Description : Circular return-address stack with top pointer, saturating
//                count and registered overflow/underflow pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module ras_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic [XLEN-1:0]              push_addr_i,
  input  logic                         pop_i,
  output logic [XLEN-1:0]              top_o,
  output logic [$clog2(RAS_DEPTH):0]   count_o,
  output logic                         overflow_o,
  output logic                         underflow_o
);

  localparam int c_PTR_W = $clog2(RAS_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [XLEN-1:0]    r_mem [RAS_DEPTH];
  logic [c_PTR_W-1:0] r_topPtr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_overflow;
  logic               r_underflow;

  logic [c_PTR_W-1:0] w_ptrInc;
  logic [c_PTR_W-1:0] w_ptrDec;
  logic               w_empty;
  logic               w_full;

  // The pointer width equals log2(depth), so increment/decrement wrap for free
  assign w_ptrInc = r_topPtr + c_PTR_W'(1);
  assign w_ptrDec = r_topPtr - c_PTR_W'(1);
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == c_CNT_W'(RAS_DEPTH));

  // Pointer, count and flag bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_topPtr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      // A push paired with a pop on a non-empty stack replaces the top in
      // place, so it never overflows.
      r_overflow  <= push_i & ~pop_i & w_full;
      r_underflow <= pop_i & w_empty;
      if (push_i && pop_i) begin
        // Empty case degenerates to underflow plus an ordinary push
        if (w_empty) begin
          r_topPtr <= w_ptrInc;
          r_count  <= r_count + c_CNT_W'(1);
        end
      end else if (push_i) begin
        r_topPtr <= w_ptrInc;
        if (!w_full) begin
          r_count <= r_count + c_CNT_W'(1);
        end
      end else if (pop_i && !w_empty) begin
        r_topPtr <= w_ptrDec;
        r_count  <= r_count - c_CNT_W'(1);
      end
    end
  end

  // Entry storage; contents after reset are don't-care so no reset here
  always_ff @(posedge clk) begin
    if (push_i) begin
      if (pop_i && !w_empty) begin
        r_mem[r_topPtr] <= push_addr_i;
      end else begin
        r_mem[w_ptrInc] <= push_addr_i;
      end
    end
  end

  assign top_o       = r_mem[r_topPtr];
  assign count_o     = r_count;
  assign overflow_o  = r_overflow;
  assign underflow_o = r_underflow;

endmodule
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_unit
//  Description : Fetch program counter with prioritised next-PC selection
//                (redirect, stall, return-address prediction, sequential).
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int              INSTR_BYTES  = 4,
  parameter int              RAS_DEPTH    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        stall_i,
  input  logic                        redirect_valid_i,
  input  logic [XLEN-1:0]             redirect_pc_i,
  input  logic                        push_i,
  input  logic [XLEN-1:0]             push_addr_i,
  input  logic                        pop_i,
  output logic [XLEN-1:0]             pc_o,
  output logic [$clog2(RAS_DEPTH):0]  ras_count_o,
  output logic                        ras_overflow_o,
  output logic                        ras_underflow_o,
  output logic                        misalign_o
);

  localparam logic [XLEN-1:0] c_ALIGN_MASK = XLEN'(alignMask(INSTR_BYTES));
  localparam logic [XLEN-1:0] c_INCR       = XLEN'(INSTR_BYTES);

  logic [XLEN-1:0] r_pc;
  logic            r_misalign;

  npc_sel_e        w_npcSel;
  logic [XLEN-1:0] w_nextPc;
  logic [XLEN-1:0] w_rasTop;
  logic            w_rasPush;
  logic            w_rasPop;
  logic            w_misalign;

  // Redirect and stall both freeze the stack; the stack is not checkpointed
  assign w_rasPush  = push_i & ~redirect_valid_i & ~stall_i;
  assign w_rasPop   = pop_i  & ~redirect_valid_i & ~stall_i;
  assign w_misalign = redirect_valid_i & (|(redirect_pc_i & ~c_ALIGN_MASK));

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (w_rasPush),
    .push_addr_i (push_addr_i),
    .pop_i       (w_rasPop),
    .top_o       (w_rasTop),
    .count_o     (ras_count_o),
    .overflow_o  (ras_overflow_o),
    .underflow_o (ras_underflow_o)
  );

  // Next-PC source priority: redirect > stall > stack prediction > sequential
  always_comb begin
    w_npcSel = NPC_SEQ;
    if (redirect_valid_i) begin
      w_npcSel = NPC_REDIRECT;
    end else if (stall_i) begin
      w_npcSel = NPC_HOLD;
    end else if (pop_i && (ras_count_o != '0)) begin
      w_npcSel = NPC_RAS;
    end
  end

  // Next-PC value for the selected source
  always_comb begin
    w_nextPc = r_pc + c_INCR;
    case (w_npcSel)
      NPC_REDIRECT: w_nextPc = redirect_pc_i & c_ALIGN_MASK;
      NPC_HOLD:     w_nextPc = r_pc;
      NPC_RAS:      w_nextPc = w_rasTop;
      default:      w_nextPc = r_pc + c_INCR;
    endcase
  end

  // PC register and misalignment pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_VECTOR;
      r_misalign <= 1'b0;
    end else begin
      r_pc       <= w_nextPc;
      r_misalign <= w_misalign;
    end
  end

  assign pc_o       = r_pc;
  assign misalign_o = r_misalign;

endmodule
`default_nettype wire
